event_latch_bank: RTL and testbench

Parametrised bank of one-shot arm/fire event latches for the HDMI processing pipeline. Each channel is armed by a request, fires once on a later trigger, and raises a sticky flag until it is acknowledged. Each channel also has a saturating event counter and an optional hold-off window before it can re-arm. Typical uses are frame-start, sync-loss and buffer-underrun event capture feeding the status/interrupt logic.

---
 rtl/event_latch_bank.sv | 146 ++++++++++++++
 tb/tb_event_latch_bank.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/event_latch_bank.sv
// ---------------------------------------------------------------------------
// event_latch_bank
//
// A bank of independent one-shot arm/fire event latches. A channel is armed
// by ARM and fires once on a later TRIG. A fire raises a sticky FLAG that
// stays set until ACK, and bumps a saturating per-channel event counter. After
// a fire the channel can sit in a hold-off window before it returns to ARMED
// (AUTO_REARM=1) or to IDLE (AUTO_REARM=0).
//
// Parameters
//   CH         number of channels (>=1)
//   COUNT_W    width of each event counter (>=1)
//   HOLDOFF    cycles spent in HOLD after a fire, 0 = no hold-off (< 2^16)
//   AUTO_REARM 1 = re-arm after fire/hold-off, 0 = return to IDLE
//
// Ports
//   CLK      rising-edge clock
//   RST_N    asynchronous active-low reset
//   ARM      per-channel arm request (level)
//   TRIG     per-channel trigger (level)
//   ACK      per-channel sticky flag clear
//   CNT_CLR  per-channel counter clear
//   FIRE     one-cycle registered pulse per accepted trigger
//   FLAG     sticky event flag
//   ARMED    1 while the channel is in ARMED
//   COUNT    event counters, channel i at [i*COUNT_W +: COUNT_W]
//   IRQ      registered OR of all FLAG bits
// ---------------------------------------------------------------------------
module event_latch_bank #(
  parameter int CH         = 4,
  parameter int COUNT_W    = 8,
  parameter int HOLDOFF    = 16,
  parameter int AUTO_REARM = 0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [CH-1:0]         ARM,
  input  logic [CH-1:0]         TRIG,
  input  logic [CH-1:0]         ACK,
  input  logic [CH-1:0]         CNT_CLR,
  output logic [CH-1:0]         FIRE,
  output logic [CH-1:0]         FLAG,
  output logic [CH-1:0]         ARMED,
  output logic [CH*COUNT_W-1:0] COUNT,
  output logic                  IRQ
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // The hold counter counts HOLDOFF-1 down to 0, giving exactly HOLDOFF
  // cycles in HOLD.
  localparam logic [15:0] HOLD_LOAD = (HOLDOFF > 0) ? 16'(HOLDOFF - 1) : 16'd0;
  localparam state_t      REARM_ST  = (AUTO_REARM != 0) ? S_ARMED : S_IDLE;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  logic [CH-1:0] flag_nxt_all;
  logic          irq_p0;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t             state_p0, state_nxt;
    logic [15:0]        hold_p0, hold_nxt;
    logic               fire_acc;
    logic               fire_p0;
    logic               flag_p0, flag_nxt;
    logic [COUNT_W-1:0] count_p0, count_nxt;

    always_comb begin
      state_nxt = state_p0;
      hold_nxt  = hold_p0;
      fire_acc  = 1'b0;
      case (state_p0)
        S_IDLE: begin
          // A trigger in the arming cycle is deliberately not accepted.
          if (ARM[i]) state_nxt = S_ARMED;
        end
        S_ARMED: begin
          if (TRIG[i]) begin
            fire_acc = 1'b1;
            if (HOLDOFF > 0) begin
              state_nxt = S_HOLD;
              hold_nxt  = HOLD_LOAD;
            end else begin
              state_nxt = REARM_ST;
            end
          end
        end
        S_HOLD: begin
          if (hold_p0 == 16'd0) state_nxt = REARM_ST;
          else                  hold_nxt  = hold_p0 - 16'd1;
        end
        default: state_nxt = S_IDLE;
      endcase
    end

    // A fire takes priority over ACK on the flag and over CNT_CLR on the
    // counter (a clear coinciding with a fire leaves the count at 1).
    always_comb begin
      flag_nxt = flag_p0;
      if (fire_acc)    flag_nxt = 1'b1;
      else if (ACK[i]) flag_nxt = 1'b0;

      count_nxt = count_p0;
      if (fire_acc)        count_nxt = CNT_CLR[i] ? COUNT_W'(1) : sat_inc(count_p0);
      else if (CNT_CLR[i]) count_nxt = '0;
    end

    // Stage p0: registered channel state and outputs
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        state_p0 <= S_IDLE;
        hold_p0  <= '0;
        fire_p0  <= 1'b0;
        flag_p0  <= 1'b0;
        count_p0 <= '0;
      end else begin
        state_p0 <= state_nxt;
        hold_p0  <= hold_nxt;
        fire_p0  <= fire_acc;
        flag_p0  <= flag_nxt;
        count_p0 <= count_nxt;
      end
    end

    assign flag_nxt_all[i]                = flag_nxt;
    assign FIRE[i]                        = fire_p0;
    assign FLAG[i]                        = flag_p0;
    assign ARMED[i]                       = (state_p0 == S_ARMED);
    assign COUNT[i*COUNT_W +: COUNT_W]    = count_p0;
  end

  // Stage p0: IRQ built from next-state flags so it lines up with FLAG
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) irq_p0 <= 1'b0;
    else        irq_p0 <= |flag_nxt_all;
  end

  assign IRQ = irq_p0;

endmodule

// File: tb/tb_event_latch_bank.sv
module tb_event_latch_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A: default parameters
  logic [3:0]  a_arm, a_trig, a_ack, a_clr;
  logic [3:0]  a_fire, a_flag, a_armed;
  logic [31:0] a_count;
  logic        a_irq;

  // Instance B: saturation, no hold-off, auto re-arm
  logic       b_arm, b_trig, b_ack, b_clr;
  logic       b_fire, b_flag, b_armed, b_irq;
  logic [1:0] b_count;

  // Instance C: hold-off of 3, auto re-arm
  logic       c_arm, c_trig, c_ack, c_clr;
  logic       c_fire, c_flag, c_armed, c_irq;
  logic [7:0] c_count;

  event_latch_bank u_a (
    .CLK(clk), .RST_N(rst_n), .ARM(a_arm), .TRIG(a_trig), .ACK(a_ack),
    .CNT_CLR(a_clr), .FIRE(a_fire), .FLAG(a_flag), .ARMED(a_armed),
    .COUNT(a_count), .IRQ(a_irq)
  );

  event_latch_bank #(.CH(1), .COUNT_W(2), .HOLDOFF(0), .AUTO_REARM(1)) u_b (
    .CLK(clk), .RST_N(rst_n), .ARM(b_arm), .TRIG(b_trig), .ACK(b_ack),
    .CNT_CLR(b_clr), .FIRE(b_fire), .FLAG(b_flag), .ARMED(b_armed),
    .COUNT(b_count), .IRQ(b_irq)
  );

  event_latch_bank #(.CH(1), .COUNT_W(8), .HOLDOFF(3), .AUTO_REARM(1)) u_c (
    .CLK(clk), .RST_N(rst_n), .ARM(c_arm), .TRIG(c_trig), .ACK(c_ack),
    .CNT_CLR(c_clr), .FIRE(c_fire), .FLAG(c_flag), .ARMED(c_armed),
    .COUNT(c_count), .IRQ(c_irq)
  );

  // Vector for instance A: inputs plus expected {FIRE,FLAG,ARMED,COUNT,IRQ}
  typedef struct {
    logic [3:0]  arm, trig, ack, clr;
    logic [44:0] exp;
  } vec_t;

  typedef struct {
    int          which;
    logic [63:0] val;
    string       tag;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [63:0] actual(input int w);
    case (w)
      0:       return 64'({a_fire, a_flag, a_armed, a_count, a_irq});
      1:       return 64'({b_fire, b_flag, b_armed, b_count, b_irq});
      default: return 64'({c_fire, c_flag, c_armed, c_count, c_irq});
    endcase
  endfunction

  function automatic void add(input logic [3:0] arm, trig, ack, clr,
                              input logic [3:0] fire, flag, armed,
                              input logic [7:0] c0, c1, c2, c3,
                              input logic irq);
    vec_t v;
    v.arm = arm; v.trig = trig; v.ack = ack; v.clr = clr;
    v.exp = {fire, flag, armed, c3, c2, c1, c0, irq};
    tbl.push_back(v);
  endfunction

  task automatic chk(input int w, input logic [63:0] exp, input string tag);
    logic [63:0] act;
    act = actual(w);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Wait for the edge, then pop the expectation pushed at drive time.
  task automatic settle;
    sb_t e;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sbq.pop_front();
      chk(e.which, e.val, e.tag);
    end
  endtask

  task automatic push(input int w, input logic [63:0] v, input string tag);
    sb_t e;
    e.which = w; e.val = v; e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic clear_inputs;
    a_arm = '0; a_trig = '0; a_ack = '0; a_clr = '0;
    b_arm = 0; b_trig = 0; b_ack = 0; b_clr = 0;
    c_arm = 0; c_trig = 0; c_ack = 0; c_clr = 0;
  endtask

  task automatic step_a(input logic [3:0] arm, trig, ack, clr,
                        input logic [44:0] exp, input string tag);
    @(negedge clk);
    a_arm = arm; a_trig = trig; a_ack = ack; a_clr = clr;
    push(0, 64'(exp), tag);
    settle();
  endtask

  task automatic step_b(input logic arm, trig, ack, clr,
                        input logic [5:0] exp, input string tag);
    @(negedge clk);
    b_arm = arm; b_trig = trig; b_ack = ack; b_clr = clr;
    push(1, 64'(exp), tag);
    settle();
  endtask

  task automatic step_c(input logic arm, trig, ack, clr,
                        input logic [11:0] exp, input string tag);
    @(negedge clk);
    c_arm = arm; c_trig = trig; c_ack = ack; c_clr = clr;
    push(2, 64'(exp), tag);
    settle();
  endtask

  initial begin
    logic [1:0] sat_seq [6];
    sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    // ---- Table for instance A ----
    // arm ch0, fire, 16-cycle hold, return to IDLE
    add(4'b0001, 0, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0);
    add(0, 4'b0001, 0, 0, 4'b0001, 4'b0001, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) add(0, 0, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 0, 1);
    add(4'b0001, 0, 0, 0, 0, 4'b0001, 0, 1, 0, 0, 0, 1);         // last HOLD cycle
    add(4'b0001, 0, 0, 0, 0, 4'b0001, 4'b0001, 1, 0, 0, 0, 1);   // IDLE again
    add(0, 0, 4'b0001, 0, 0, 0, 4'b0001, 1, 0, 0, 0, 0);
    // ch1: ignored triggers
    add(0, 4'b0010, 0, 0, 0, 0, 4'b0001, 1, 0, 0, 0, 0);
    add(4'b0010, 4'b0010, 0, 0, 0, 0, 4'b0011, 1, 0, 0, 0, 0);
    add(0, 4'b0010, 0, 0, 4'b0010, 4'b0010, 4'b0001, 1, 1, 0, 0, 1);
    add(0, 0, 4'b0010, 0, 0, 0, 4'b0001, 1, 1, 0, 0, 0);
    // ch2: ACK with fire, then count up to 7
    add(4'b0100, 0, 0, 0, 0, 0, 4'b0101, 1, 1, 0, 0, 0);
    add(0, 4'b0100, 4'b0100, 0, 4'b0100, 4'b0100, 4'b0001, 1, 1, 1, 0, 1);
    for (int n = 2; n <= 7; n++) begin
      for (int i = 0; i < 16; i++)
        add(0, 0, 0, 0, 0, 4'b0100, 4'b0001, 1, 1, 8'(n - 1), 0, 1);
      add(4'b0100, 0, 0, 0, 0, 4'b0100, 4'b0101, 1, 1, 8'(n - 1), 0, 1);
      add(0, 4'b0100, 0, 0, 4'b0100, 4'b0100, 4'b0001, 1, 1, 8'(n), 0, 1);
    end
    for (int i = 0; i < 16; i++)
      add(0, 0, 0, 0, 0, 4'b0100, 4'b0001, 1, 1, 7, 0, 1);
    add(4'b0100, 0, 0, 0, 0, 4'b0100, 4'b0101, 1, 1, 7, 0, 1);
    add(0, 4'b0100, 0, 4'b0100, 4'b0100, 4'b0100, 4'b0001, 1, 1, 1, 0, 1); // clr+fire
    add(0, 0, 0, 4'b0100, 0, 4'b0100, 4'b0001, 1, 1, 0, 0, 1);             // clr alone
    add(0, 0, 4'b0100, 0, 0, 0, 4'b0001, 1, 1, 0, 0, 0);                    // ack alone

    // ---- Reset state ----
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk(0, 64'd0, "reset_a");
    chk(1, 64'd0, "reset_b");
    chk(2, 64'd0, "reset_c");
    @(negedge clk);
    rst_n = 1'b1;

    // ---- Instance B: saturation with continuous firing ----
    step_b(1, 0, 0, 0, {1'b0, 1'b0, 1'b1, 2'd0, 1'b0}, "b_arm");
    for (int i = 0; i < 6; i++)
      step_b(0, 1, 0, 0, {1'b1, 1'b1, 1'b1, sat_seq[i], 1'b1}, $sformatf("b_sat%0d", i));
    step_b(0, 0, 0, 0, {1'b0, 1'b1, 1'b1, 2'd3, 1'b1}, "b_trig_low");
    step_b(0, 0, 0, 1, {1'b0, 1'b1, 1'b1, 2'd0, 1'b1}, "b_cnt_clr");
    step_b(0, 0, 1, 0, {1'b0, 1'b0, 1'b1, 2'd0, 1'b0}, "b_ack");
    @(negedge clk);
    b_ack = 0;

    // ---- Instance C: hold-off spacing with TRIG held high ----
    step_c(1, 0, 0, 0, {1'b0, 1'b0, 1'b1, 8'd0, 1'b0}, "c_arm");
    for (int j = 0; j < 12; j++)
      step_c(0, 1, 0, 0, {(j % 4 == 0), 1'b1, (j % 4 == 3), 8'(j / 4 + 1), 1'b1},
             $sformatf("c_spacing%0d", j));
    @(negedge clk);
    c_trig = 0;

    // ---- Instance A: table ----
    for (int i = 0; i < tbl.size(); i++)
      step_a(tbl[i].arm, tbl[i].trig, tbl[i].ack, tbl[i].clr, tbl[i].exp,
             $sformatf("a_vec%0d", i));

    // ---- Instance A: reset while FIRE is high and the channel is in HOLD ----
    step_a(0, 4'b0001, 0, 0, {4'b0001, 4'b0001, 4'b0000, 8'd0, 8'd0, 8'd1, 8'd2, 1'b1},
           "a_prefire");
    #2;
    rst_n = 1'b0;
    #1;
    chk(0, 64'd0, "a_async_reset");
    @(negedge clk);
    a_trig = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step_a(0, 4'b0001, 0, 0, 45'd0, "a_post_reset_trig");
    step_a(4'b0001, 0, 0, 0, {4'b0, 4'b0, 4'b0001, 32'd0, 1'b0}, "a_post_reset_arm");
    step_a(0, 4'b0001, 0, 0, {4'b0001, 4'b0001, 4'b0, 8'd0, 8'd0, 8'd0, 8'd1, 1'b1},
           "a_post_reset_fire");
    step_a(0, 0, 0, 0, {4'b0, 4'b0001, 4'b0, 8'd0, 8'd0, 8'd0, 8'd1, 1'b1},
           "a_post_reset_pulse_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
